kd_query_scheduler: RTL
=======================

Name: kd_query_scheduler

Overview:
- Sequences the kd-tree search block: first a node-load phase, then a query phase that shares the tree's two patch lanes (A, B) among NREQ requesters.
- In the load phase it asserts fsm_enable while the aggregator streams internal nodes, and counts accepted node words.
- In the query phase it grants up to two requesters per cycle in round-robin order and tags each issued patch.
- Leaf indices returned by the tree are routed back to the requester that issued the patch.

Parameters:
- NREQ, 4, number of query requesters (power of 2, at least 2)
- PATCH_WIDTH, 55, patch width (5 x 11-bit)
- ADDRESS_WIDTH, 8, leaf index width
- NUM_NODES, 255, internal-node words to accept before querying
- MAX_OUT, 4, max outstanding queries per lane (tag FIFO depth, power of 2)

Ports:
- wclk  in  1  clock
- wrst_n  in  1  synchronous active-low reset
- start_load  in  1  request a (re)load of tree nodes
- node_valid  in  1  one node word accepted by tree (aggregator enq)
- fsm_enable  out  1  tree node-write enable
- load_done  out  1  one-cycle pulse when load completes
- req_valid  in  NREQ  per-requester patch valid
- req_patch  in  NREQ*PATCH_WIDTH  per-requester patch, requester i at slice i
- req_ready  out  NREQ  grant; handshake when valid & ready
- patch_en  out  1  lane A issue
- patch_in  out  PATCH_WIDTH  lane A patch
- patch_two_en  out  1  lane B issue
- patch_in_two  out  PATCH_WIDTH  lane B patch
- leaf_valid  in  1  tree lane A result valid
- leaf_index  in  ADDRESS_WIDTH  lane A result
- leaf_two_valid  in  1  tree lane B result valid
- leaf_index_two  in  ADDRESS_WIDTH  lane B result
- resp_a_valid  out  1  routed lane A response
- resp_a_id  out  log2(NREQ)  requester id for resp_a
- resp_a_index  out  ADDRESS_WIDTH  leaf index for resp_a
- resp_b_valid, resp_b_id, resp_b_index  out  same widths as resp_a  lane B response
- busy  out  1  state != QUERY or any outstanding query
- rsp_err  out  1  sticky: result arrived with empty tag FIFO

Behaviour:
- Reset values: state = IDLE. All outputs 0, including both patch buses, rr_ptr, node count, both tag FIFOs and rsp_err. busy = 1.
- Reset mid-operation discards all tags; the tree is expected to be reset alongside this block.
- IDLE state:
  - fsm_enable = 0 and no grants.
  - start_load moves to LOAD on the next edge.
- LOAD state:
  - fsm_enable = 1 (registered).
  - Each node_valid increments the count.
  - node_valid while count == NUM_NODES-1: go to QUERY, clear the count, deassert fsm_enable, pulse load_done for one cycle.
  - start_load during LOAD is ignored.
- QUERY state:
  - start_load with both tag FIFOs empty: go to LOAD and clear the count.
  - start_load with any tag FIFO non-empty: ignored.
  - node_valid is ignored.
- Arbitration (QUERY only; req_ready is combinational from req_valid, rr_ptr and FIFO state):
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first valid requester goes to lane A if its FIFO count < MAX_OUT. The next valid requester goes to lane B if its FIFO count < MAX_OUT.
  - If only one lane has room, grant only the first valid requester to that lane.
  - A requester never gets both lanes in one cycle.
  - rr_ptr becomes (last granted id + 1) mod NREQ; it is unchanged if nothing is granted.
- Issue:
  - Issue registers are loaded on the handshake edge, so patch_en / patch_two_en are high in the following cycle, for exactly one cycle per grant.
  - The granted id is pushed into that lane's tag FIFO on the same edge.
  - Patch buses hold their last value when not enabled.
- Return:
  - leaf_valid pops the lane A FIFO. On the next cycle resp_a_valid = 1, resp_a_id = popped id, resp_a_index = leaf_index as registered. Lane B is identical and independent.
  - Results are assumed in order within a lane.
  - leaf_valid with an empty FIFO: no response, rsp_err is set until reset.
  - Same-edge push and pop on one lane is allowed. The count is unchanged; fullness for granting is evaluated on the pre-edge count, so no grant is made when the count == MAX_OUT even if a pop occurs that edge.
- busy = (state != QUERY) | FIFO A non-empty | FIFO B non-empty.

Test Plan:
- Load: reset, start_load, 255 node_valid pulses with random gaps -> fsm_enable high from the cycle after start_load until the edge of the 255th pulse; load_done single pulse; state QUERY; extra node_valid does not change the count.
- Dual grant: rr_ptr = 0, req_valid = 4'b1010 -> req_ready = 4'b1010. Next cycle patch_en carries requester 1's patch and patch_two_en carries requester 3's patch. rr_ptr = 0.
- Routing: tree returns leaf_index = 59 on lane A and leaf_index_two = 60 on lane B -> resp_a = (id 1, 59) and resp_b = (id 3, 60), one cycle later.
- Fairness: all 4 requesters valid continuously, results returned promptly -> grants (0,1), (2,3), (0,1)...; each requester served once per 2 cycles.
- Backpressure: withhold lane A results after 4 issues -> lane A stalls and lane B alone serves the first valid requester. One leaf_valid frees one slot; the next grant occurs one cycle later.
- Errors: leaf_two_valid with an empty FIFO -> no resp_b_valid, rsp_err = 1 until wrst_n. start_load with outstanding queries is ignored. Reset mid-LOAD -> IDLE, all outputs 0.

Source files
------------

// File: rtl/kd_query_scheduler.sv
// Load/query sequencer for the kd-tree search block: counts node words during load,
// then shares the two patch lanes among NREQ requesters and routes leaf results back.
module kd_query_scheduler #(
  parameter int NREQ          = 4,
  parameter int PATCH_WIDTH   = 55,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_NODES     = 255,
  parameter int MAX_OUT       = 4
) (
  input  logic                            wclk,
  input  logic                            wrst_n,
  input  logic                            start_load,
  input  logic                            node_valid,
  output logic                            fsm_enable,
  output logic                            load_done,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ*PATCH_WIDTH-1:0]     req_patch,
  output logic [NREQ-1:0]                 req_ready,
  output logic                            patch_en,
  output logic [PATCH_WIDTH-1:0]          patch_in,
  output logic                            patch_two_en,
  output logic [PATCH_WIDTH-1:0]          patch_in_two,
  input  logic                            leaf_valid,
  input  logic [ADDRESS_WIDTH-1:0]        leaf_index,
  input  logic                            leaf_two_valid,
  input  logic [ADDRESS_WIDTH-1:0]        leaf_index_two,
  output logic                            resp_a_valid,
  output logic [$clog2(NREQ)-1:0]         resp_a_id,
  output logic [ADDRESS_WIDTH-1:0]        resp_a_index,
  output logic                            resp_b_valid,
  output logic [$clog2(NREQ)-1:0]         resp_b_id,
  output logic [ADDRESS_WIDTH-1:0]        resp_b_index,
  output logic                            busy,
  output logic                            rsp_err
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CW   = $clog2(NUM_NODES + 1);
  localparam int PTRW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW   = $clog2(MAX_OUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_QUERY = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] node_cnt_q, node_cnt_d;
  logic          fsm_en_q, fsm_en_d;
  logic          load_done_q, load_done_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [1:0]            push, pop_req, pop_ok, lane_empty, lane_room;
  logic [1:0][IDW-1:0]   push_id, head_id;

  logic [PATCH_WIDTH-1:0] patch_arr [NREQ];

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_patch
      assign patch_arr[gi] = req_patch[gi*PATCH_WIDTH +: PATCH_WIDTH];
    end
  endgenerate

  // One in-order tag FIFO per lane holding the requester id of each issued patch.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [IDW-1:0]  mem_q [MAX_OUT];
      logic [PTRW-1:0] wr_q, rd_q;
      logic [OW-1:0]   cnt_q;

      always_ff @(posedge wclk) begin
        if (!wrst_n) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
          for (int i = 0; i < MAX_OUT; i++) mem_q[i] <= '0;
        end else begin
          if (push[gi]) begin
            mem_q[wr_q] <= push_id[gi];
            wr_q        <= ptr_inc(wr_q);
          end
          if (pop_ok[gi]) rd_q <= ptr_inc(rd_q);
          if (push[gi] && !pop_ok[gi])      cnt_q <= cnt_q + 1'b1;
          else if (!push[gi] && pop_ok[gi]) cnt_q <= cnt_q - 1'b1;
        end
      end

      assign head_id[gi]    = mem_q[rd_q];
      assign lane_empty[gi] = (cnt_q == '0);
      // Room uses the pre-edge count, so a same-edge pop never frees a slot early.
      assign lane_room[gi]  = (cnt_q < OW'(MAX_OUT));
      assign pop_ok[gi]     = pop_req[gi] & ~lane_empty[gi];
    end
  endgenerate

  assign pop_req = {leaf_two_valid, leaf_valid};

  logic           first_found, second_found;
  logic [IDW-1:0] first_id, second_id, scan_idx;

  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_id     = '0;
    second_id    = '0;
    scan_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = rr_ptr_q + IDW'(k);
      if (req_valid[scan_idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_id    = scan_idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_id    = scan_idx;
        end
      end
    end
  end

  logic           grant_a, grant_b;
  logic [IDW-1:0] id_a, id_b;

  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    id_a      = first_id;
    id_b      = first_id;
    req_ready = '0;
    rr_ptr_d  = rr_ptr_q;
    if (state_q == ST_QUERY && first_found) begin
      if (lane_room[0]) begin
        grant_a = 1'b1;
        if (lane_room[1] && second_found) begin
          grant_b = 1'b1;
          id_b    = second_id;
        end
      end else if (lane_room[1]) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) req_ready[id_a] = 1'b1;
    if (grant_b) req_ready[id_b] = 1'b1;
    // Lane B's grant is always the later one in scan order when both fire.
    if (grant_b)      rr_ptr_d = id_b + 1'b1;
    else if (grant_a) rr_ptr_d = id_a + 1'b1;
  end

  assign push    = {grant_b, grant_a};
  assign push_id = {id_b, id_a};

  always_comb begin
    state_d     = state_q;
    node_cnt_d  = node_cnt_q;
    fsm_en_d    = fsm_en_q;
    load_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          state_d    = ST_LOAD;
          node_cnt_d = '0;
          fsm_en_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (node_valid) begin
          if (node_cnt_q == CW'(NUM_NODES - 1)) begin
            state_d     = ST_QUERY;
            node_cnt_d  = '0;
            fsm_en_d    = 1'b0;
            load_done_d = 1'b1;
          end else begin
            node_cnt_d = node_cnt_q + 1'b1;
          end
        end
      end
      ST_QUERY: begin
        if (start_load && (&lane_empty)) begin
          state_d    = ST_LOAD;
          node_cnt_d = '0;
          fsm_en_d   = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        fsm_en_d = 1'b0;
      end
    endcase
  end

  logic                     patch_en_q, patch_two_en_q;
  logic [PATCH_WIDTH-1:0]   patch_a_q, patch_b_q;
  logic                     resp_a_valid_q, resp_b_valid_q;
  logic [IDW-1:0]           resp_a_id_q, resp_b_id_q;
  logic [ADDRESS_WIDTH-1:0] resp_a_idx_q, resp_b_idx_q;
  logic                     rsp_err_q;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q        <= ST_IDLE;
      node_cnt_q     <= '0;
      fsm_en_q       <= 1'b0;
      load_done_q    <= 1'b0;
      rr_ptr_q       <= '0;
      patch_en_q     <= 1'b0;
      patch_two_en_q <= 1'b0;
      patch_a_q      <= '0;
      patch_b_q      <= '0;
      resp_a_valid_q <= 1'b0;
      resp_b_valid_q <= 1'b0;
      resp_a_id_q    <= '0;
      resp_b_id_q    <= '0;
      resp_a_idx_q   <= '0;
      resp_b_idx_q   <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      node_cnt_q     <= node_cnt_d;
      fsm_en_q       <= fsm_en_d;
      load_done_q    <= load_done_d;
      rr_ptr_q       <= rr_ptr_d;
      patch_en_q     <= grant_a;
      patch_two_en_q <= grant_b;
      if (grant_a) patch_a_q <= patch_arr[id_a];
      if (grant_b) patch_b_q <= patch_arr[id_b];
      resp_a_valid_q <= pop_ok[0];
      resp_b_valid_q <= pop_ok[1];
      if (pop_ok[0]) begin
        resp_a_id_q  <= head_id[0];
        resp_a_idx_q <= leaf_index;
      end
      if (pop_ok[1]) begin
        resp_b_id_q  <= head_id[1];
        resp_b_idx_q <= leaf_index_two;
      end
      rsp_err_q <= rsp_err_q | (|(pop_req & lane_empty));
    end
  end

  assign fsm_enable   = fsm_en_q;
  assign load_done    = load_done_q;
  assign patch_en     = patch_en_q;
  assign patch_in     = patch_a_q;
  assign patch_two_en = patch_two_en_q;
  assign patch_in_two = patch_b_q;
  assign resp_a_valid = resp_a_valid_q;
  assign resp_a_id    = resp_a_id_q;
  assign resp_a_index = resp_a_idx_q;
  assign resp_b_valid = resp_b_valid_q;
  assign resp_b_id    = resp_b_id_q;
  assign resp_b_index = resp_b_idx_q;
  assign busy         = (state_q != ST_QUERY) | ~(&lane_empty);
  assign rsp_err      = rsp_err_q;

endmodule
